box_datapath: RTL and testbench
===============================

Name: box_datapath

Overview:
- Datapath stage directly downstream of the box-drawing control FSM.
- Holds the X, Y and colour registers.
- Runs the 16-pixel (4x4) box offset counter and the full-screen black-fill scan counter.
- Presents pixel coordinates, colour, a gated plot strobe and the progress counter consumed by the FSM and the VGA adapter on a 160x120 display.

Parameters:
- SCREEN_W, 160, horizontal pixels; black scan x wraps at SCREEN_W-1.
- SCREEN_H, 120, vertical pixels; black scan y wraps at SCREEN_H-1.
- BOX_BITS, 2, log2 of box side; box is 4x4, offset counter is 2*BOX_BITS = 4 bits.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high; clears all registers; dominates every enable.
- DataIn  in  7  shared switch input; loaded as X (zero-extended) or as Y.
- ColorIn  in  3  colour switch input.
- enRegX  in  1  load X register from DataIn.
- enRegY  in  1  load Y register from DataIn.
- enColor  in  1  load colour register from ColorIn.
- enCount  in  1  advance box offset counter.
- enALU  in  1  apply box offset to X/Y outputs.
- enBlackCount  in  1  advance black scan counters.
- SelectPath  in  1  1 = box path, 0 = black-fill path.
- Plot  in  1  plot request from control.
- counter  out  15  progress count to control FSM.
- XOut  out  8  pixel x.
- YOut  out  7  pixel y.
- ColorOut  out  3  pixel colour.
- PlotOut  out  1  plot strobe to VGA adapter, gated by on-screen check.

Behaviour:
- Registers: RegX[7:0], RegY[6:0], RegC[2:0], BoxCnt[3:0], BlkCnt[14:0], BlkX[7:0], BlkY[6:0]; all 0 after Reset.
- Reset high on a rising edge clears every register regardless of enables, including X/don't-care enables.
- Loads: enRegX -> RegX <= {1'b0,DataIn}; enRegY -> RegY <= DataIn; enColor -> RegC <= ColorIn. Each takes effect at the next edge; the register holds otherwise.
- Y bypass: while enRegY=1, the Y base used for outputs is DataIn, not RegY. The first box pixel, plotted in the load-Y cycle, therefore uses the new Y.
- BoxCnt: increments by 1 on each edge with enCount=1. Wraps 15 -> 0. Holds otherwise.
- Black scan, on each edge with enBlackCount=1:
  - BlkCnt += 1.
  - BlkX += 1.
  - If BlkX = SCREEN_W-1: BlkX <= 0, BlkY += 1.
  - If BlkY = SCREEN_H-1 and BlkX = SCREEN_W-1: BlkY <= 0 and BlkCnt <= 0 (wrap after 19199).
- enCount and enBlackCount asserted together: both counters advance independently.
- Box path (SelectPath=1), combinational:
  - Offsets: ox = BoxCnt[1:0], oy = BoxCnt[3:2], applied only when enALU=1, else 0.
  - Sums: xs = RegX + ox (8-bit); ys = {1'b0,Ybase} + oy (8-bit).
  - XOut = xs, YOut = ys[6:0], ColorOut = RegC, counter = {11'b0,BoxCnt}.
- Black path (SelectPath=0): XOut = BlkX, YOut = BlkY, ColorOut = 3'b000, counter = BlkCnt.
- On-screen check: box path x < SCREEN_W and ys < SCREEN_H (8-bit compare, so ys >= 120 including overflow past 127 is off-screen); black path always on-screen.
- PlotOut = Plot AND on-screen. All outputs are combinational from registers, zero added latency.
- Box sequence timing from the load-Y cycle:
  - Load-Y cycle plots offset 0.
  - Draw cycles present BoxCnt 0..15; control exits after counter = 15. Offset 0 plotted twice, harmless.
  - counter reads 15 on the final draw cycle.
- Reset mid-box or mid-scan: all counts return to 0 on the next edge, so a restarted draw begins at offset 0.

Test Plan:
- Reset with all enables = 1 -> next cycle every register 0, counter = 0, XOut = 0, YOut = 0, ColorOut = 0.
- Load X: DataIn = 10, ColorIn = 3'b101, enRegX = enColor = 1 for 1 cycle -> RegX = 10, ColorOut = 5.
- Load Y then draw: DataIn = 20, enRegY = enALU = Plot = 1 -> same cycle YOut = 20 (bypass). Then 16 cycles with enCount = 1 -> (XOut,YOut) steps (10,20),(11,20),(12,20),(13,20),(10,21) ... (13,23); counter 0..15; PlotOut = 1 throughout.
- Clipping: RegX = 127, Y = 118, box draw -> PlotOut = 0 for pixels with y = 120,121 (counter 8..15); x = 130 is still plotted.
- Black fill: SelectPath = 0, enBlackCount = 1 for 19200 cycles -> ColorOut = 0; at counter = 159, (XOut,YOut) = (159,0); next cycle (0,1); at counter = 19199, (159,119); next cycle counter = 0, (0,0).
- Reset mid-scan at counter = 500 -> next cycle counter = 0, BlkX = BlkY = 0.

Source files
------------

// File: rtl/box_datapath.sv
// box_datapath: X/Y/colour registers, 4x4 box offset counter and full-screen
// black-fill scan counter feeding a 160x120 VGA adapter. All outputs are
// combinational from registered state (plus the Y bypass), so a control
// decision made in a cycle is visible on the pixel bus in that same cycle.
module box_datapath #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BOX_BITS = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [6:0]  DataIn,
  input  logic [2:0]  ColorIn,
  input  logic        enRegX,
  input  logic        enRegY,
  input  logic        enColor,
  input  logic        enCount,
  input  logic        enALU,
  input  logic        enBlackCount,
  input  logic        SelectPath,
  input  logic        Plot,
  output logic [14:0] counter,
  output logic [7:0]  XOut,
  output logic [6:0]  YOut,
  output logic [2:0]  ColorOut,
  output logic        PlotOut
);

  localparam int          CNT_W  = 2 * BOX_BITS;
  localparam logic [7:0]  X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0]  X_LIM  = 8'(SCREEN_W);
  localparam logic [7:0]  Y_LIM  = 8'(SCREEN_H);

  logic [7:0]       reg_x_q,   reg_x_d;
  logic [6:0]       reg_y_q,   reg_y_d;
  logic [2:0]       reg_c_q,   reg_c_d;
  logic [CNT_W-1:0] box_cnt_q, box_cnt_d;
  logic [14:0]      blk_cnt_q, blk_cnt_d;
  logic [7:0]       blk_x_q,   blk_x_d;
  logic [6:0]       blk_y_q,   blk_y_d;

  // Box-path intermediate values
  logic [6:0]          y_base;
  logic [BOX_BITS-1:0] off_x;
  logic [BOX_BITS-1:0] off_y;
  logic [7:0]          x_sum;
  logic [7:0]          y_sum;
  logic                on_screen;

  // Next-state for the coordinate/colour registers: plain load-or-hold
  always_comb begin
    reg_x_d = reg_x_q;
    reg_y_d = reg_y_q;
    reg_c_d = reg_c_q;
    if (enRegX)  reg_x_d = {1'b0, DataIn};
    if (enRegY)  reg_y_d = DataIn;
    if (enColor) reg_c_d = ColorIn;
  end

  // Next-state for the box offset counter; natural wrap 15 -> 0
  always_comb begin
    box_cnt_d = box_cnt_q;
    if (enCount) box_cnt_d = box_cnt_q + CNT_W'(1);
  end

  // Next-state for the raster scan: x wraps at the right edge and bumps y;
  // the last pixel of the last row wraps the whole scan back to the origin
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blk_x_d   = blk_x_q;
    blk_y_d   = blk_y_q;
    if (enBlackCount) begin
      blk_cnt_d = blk_cnt_q + 15'd1;
      blk_x_d   = blk_x_q + 8'd1;
      if (blk_x_q == X_LAST) begin
        blk_x_d = 8'd0;
        blk_y_d = blk_y_q + 7'd1;
        if (blk_y_q == Y_LAST) begin
          blk_y_d   = 7'd0;
          blk_cnt_d = 15'd0;
        end
      end
    end
  end

  // State registers; reset dominates every enable
  always_ff @(posedge Clock) begin
    if (Reset) begin
      reg_x_q   <= '0;
      reg_y_q   <= '0;
      reg_c_q   <= '0;
      box_cnt_q <= '0;
      blk_cnt_q <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
    end else begin
      reg_x_q   <= reg_x_d;
      reg_y_q   <= reg_y_d;
      reg_c_q   <= reg_c_d;
      box_cnt_q <= box_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      blk_x_q   <= blk_x_d;
      blk_y_q   <= blk_y_d;
    end
  end

  // Box pixel address: the Y bypass lets the first pixel be plotted in the
  // load-Y cycle; sums are 8 bits wide so rows past 127 are still seen as
  // off-screen rather than aliasing back onto the top of the display
  always_comb begin
    y_base = enRegY ? DataIn : reg_y_q;
    off_x  = enALU ? box_cnt_q[BOX_BITS-1:0]     : '0;
    off_y  = enALU ? box_cnt_q[CNT_W-1:BOX_BITS] : '0;
    x_sum  = reg_x_q + {{(8-BOX_BITS){1'b0}}, off_x};
    y_sum  = {1'b0, y_base} + {{(8-BOX_BITS){1'b0}}, off_y};
  end

  // Output mux between the box path and the black-fill scan
  always_comb begin
    if (SelectPath) begin
      XOut      = x_sum;
      YOut      = y_sum[6:0];
      ColorOut  = reg_c_q;
      counter   = {{(15-CNT_W){1'b0}}, box_cnt_q};
      on_screen = (x_sum < X_LIM) && (y_sum < Y_LIM);
    end else begin
      XOut      = blk_x_q;
      YOut      = blk_y_q;
      ColorOut  = 3'b000;
      counter   = blk_cnt_q;
      on_screen = 1'b1;
    end
    PlotOut = Plot & on_screen;
  end

endmodule

// File: tb/tb_box_datapath.sv
// Bench for box_datapath: directed walk through box draw, clipping, full
// black fill and resets, then randomized enables. A pixel-level reference
// model (linear scan index, box offset as index/4 and index%4) predicts every
// output each cycle.
module tb_box_datapath;

  logic        Clock;
  logic        Reset;
  logic [6:0]  DataIn;
  logic [2:0]  ColorIn;
  logic        enRegX, enRegY, enColor, enCount, enALU, enBlackCount;
  logic        SelectPath, Plot;
  logic [14:0] counter;
  logic [7:0]  XOut;
  logic [6:0]  YOut;
  logic [2:0]  ColorOut;
  logic        PlotOut;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_x, m_y, m_c, m_box, m_n;

  // Expected output vector: {counter, x, y, colour, plot}
  logic [33:0] exp_q[$];

  box_datapath dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .ColorIn(ColorIn),
    .enRegX(enRegX), .enRegY(enRegY), .enColor(enColor), .enCount(enCount),
    .enALU(enALU), .enBlackCount(enBlackCount), .SelectPath(SelectPath),
    .Plot(Plot), .counter(counter), .XOut(XOut), .YOut(YOut),
    .ColorOut(ColorOut), .PlotOut(PlotOut)
  );

  // Clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    Reset = 0; DataIn = 0; ColorIn = 0;
    enRegX = 0; enRegY = 0; enColor = 0; enCount = 0;
    enALU = 0; enBlackCount = 0; SelectPath = 0; Plot = 0;
  endtask

  // Predict outputs from the model and the live inputs, then compare
  task automatic check_model();
    int ex, ey, ec, ecnt, ep, ybase;
    logic [33:0] e;
    if (SelectPath) begin
      ybase = enRegY ? int'(DataIn) : m_y;
      ex    = m_x  + (enALU ? m_box % 4 : 0);
      ey    = ybase + (enALU ? m_box / 4 : 0);
      ec    = m_c;
      ecnt  = m_box;
      ep    = (Plot && ex < 160 && ey < 120) ? 1 : 0;
    end else begin
      ex   = m_n % 160;
      ey   = m_n / 160;
      ec   = 0;
      ecnt = m_n;
      ep   = Plot ? 1 : 0;
    end
    exp_q.push_back({15'(ecnt), 8'(ex), 7'(ey % 128), 3'(ec), 1'(ep)});
    e = exp_q.pop_front();
    chk("m_counter", 32'(counter),  32'(e[33:19]));
    chk("m_xout",    32'(XOut),     32'(e[18:11]));
    chk("m_yout",    32'(YOut),     32'(e[10:4]));
    chk("m_color",   32'(ColorOut), 32'(e[3:1]));
    chk("m_plot",    32'(PlotOut),  32'(e[0]));
  endtask

  // One clock: check current outputs, clock the DUT, advance the model
  task automatic cycle();
    #1;
    check_model();
    @(posedge Clock);
    if (Reset) begin
      m_x = 0; m_y = 0; m_c = 0; m_box = 0; m_n = 0;
    end else begin
      if (enRegX)       m_x   = DataIn;
      if (enRegY)       m_y   = DataIn;
      if (enColor)      m_c   = ColorIn;
      if (enCount)      m_box = (m_box + 1) % 16;
      if (enBlackCount) m_n   = (m_n + 1) % (160 * 120);
    end
    @(negedge Clock);
  endtask

  initial begin
    m_x = 0; m_y = 0; m_c = 0; m_box = 0; m_n = 0;
    idle_inputs();

    // Reset with every enable asserted
    Reset = 1; DataIn = 7'h55; ColorIn = 3'b111;
    enRegX = 1; enRegY = 1; enColor = 1; enCount = 1;
    enALU = 1; enBlackCount = 1; SelectPath = 1; Plot = 1;
    cycle();
    idle_inputs();
    SelectPath = 1;
    #1;
    chk("rst_counter", 32'(counter), 0);
    chk("rst_xout",    32'(XOut), 0);
    chk("rst_yout",    32'(YOut), 0);
    chk("rst_color",   32'(ColorOut), 0);
    SelectPath = 0;
    #1;
    chk("rst_blkcnt",  32'(counter), 0);
    cycle();

    // Load X and colour
    DataIn = 7'd10; ColorIn = 3'b101; enRegX = 1; enColor = 1;
    cycle();
    idle_inputs();
    SelectPath = 1;
    #1;
    chk("ldx_xout",  32'(XOut), 10);
    chk("ldx_color", 32'(ColorOut), 5);

    // Load Y with bypass, then draw the 4x4 box
    DataIn = 7'd20; enRegY = 1; enALU = 1; Plot = 1;
    #1;
    chk("ldy_bypass", 32'(YOut), 20);
    chk("ldy_xout",   32'(XOut), 10);
    chk("ldy_plot",   32'(PlotOut), 1);
    cycle();
    enRegY = 0; DataIn = 7'd0; enCount = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("box_x",   32'(XOut), 32'(10 + i % 4));
      chk("box_y",   32'(YOut), 32'(20 + i / 4));
      chk("box_cnt", 32'(counter), 32'(i));
      chk("box_plot", 32'(PlotOut), 1);
      cycle();
    end

    // Clipping near the bottom edge
    idle_inputs();
    DataIn = 7'd127; enRegX = 1;
    cycle();
    idle_inputs();
    SelectPath = 1; DataIn = 7'd118; enRegY = 1; enALU = 1; Plot = 1;
    cycle();
    enRegY = 0; DataIn = 7'd0; enCount = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clip_x",    32'(XOut), 32'(127 + i % 4));
      chk("clip_plot", 32'(PlotOut), (i < 8) ? 1 : 0);
      cycle();
    end

    // Full-screen black fill
    idle_inputs();
    SelectPath = 0; enBlackCount = 1; Plot = 1;
    for (int i = 0; i < 160 * 120; i++) begin
      #1;
      if (i == 159) begin
        chk("blk_159_x", 32'(XOut), 159);
        chk("blk_159_y", 32'(YOut), 0);
        chk("blk_color", 32'(ColorOut), 0);
      end
      if (i == 160) begin
        chk("blk_160_x", 32'(XOut), 0);
        chk("blk_160_y", 32'(YOut), 1);
      end
      if (i == 19199) begin
        chk("blk_last_cnt", 32'(counter), 19199);
        chk("blk_last_x",   32'(XOut), 159);
        chk("blk_last_y",   32'(YOut), 119);
      end
      cycle();
    end
    #1;
    chk("blk_wrap_cnt", 32'(counter), 0);
    chk("blk_wrap_x",   32'(XOut), 0);
    chk("blk_wrap_y",   32'(YOut), 0);

    // Reset in the middle of a scan
    for (int i = 0; i < 500; i++) cycle();
    #1;
    chk("mid_cnt", 32'(counter), 500);
    Reset = 1;
    cycle();
    Reset = 0;
    #1;
    chk("mid_rst_cnt", 32'(counter), 0);
    chk("mid_rst_x",   32'(XOut), 0);
    chk("mid_rst_y",   32'(YOut), 0);
    cycle();

    // Randomized enables and data against the model
    for (int i = 0; i < 3000; i++) begin
      Reset        = ($urandom_range(0, 63) == 0);
      DataIn       = 7'($urandom_range(0, 127));
      ColorIn      = 3'($urandom_range(0, 7));
      enRegX       = 1'($urandom_range(0, 1));
      enRegY       = 1'($urandom_range(0, 1));
      enColor      = 1'($urandom_range(0, 1));
      enCount      = 1'($urandom_range(0, 1));
      enALU        = 1'($urandom_range(0, 1));
      enBlackCount = 1'($urandom_range(0, 1));
      SelectPath   = 1'($urandom_range(0, 1));
      Plot         = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
